// File: rtl/pmem_loader.sv
// Program-memory loader for picoMips: parses a framed byte stream (A5, N, N words, checksum),
// writes words to program memory and releases the CPU reset only after a checksum-valid image.
module pmem_loader #(
   parameter int DEPTH   = 8,
   parameter int ADDR_W  = 3,
   parameter int TIMEOUT = 1000
) (
   input  logic              Clock,
   input  logic              nReset,
   input  logic              start,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [15:0]       wr_data,
   output logic              cpu_nreset,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam int              TW       = $clog2(TIMEOUT + 1);
   localparam logic [7:0]      DEPTH_B  = 8'(DEPTH);
   localparam logic [7:0]      HDR_BYTE = 8'hA5;
   localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_HDR, S_GET_CNT, S_GET_HI, S_GET_LO, S_GET_CSUM, S_DONE, S_ERROR
   } state_t;

   state_t              state_r;
   state_t              state_nxt_s;
   logic [ADDR_W-1:0]   idx_r;
   logic [ADDR_W-1:0]   n_last_r;
   logic [7:0]          hi_r;
   logic [7:0]          csum_r;
   logic [TW-1:0]       tcnt_r;
   logic                in_frame_s;
   logic                tmo_s;

   function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
      return acc + b;
   endfunction

   function automatic logic is_busy(input state_t s);
      return (s == S_WAIT_HDR) || (s == S_GET_CNT) || (s == S_GET_HI) ||
             (s == S_GET_LO) || (s == S_GET_CSUM);
   endfunction

   // Inter-byte timeout applies only once the header has been seen.
   assign in_frame_s = (state_r == S_GET_CNT) || (state_r == S_GET_HI) ||
                       (state_r == S_GET_LO)  || (state_r == S_GET_CSUM);
   assign tmo_s      = in_frame_s && !rx_valid && (tcnt_r == TMO_LAST);

   // Next-state decode for the frame parser.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) state_nxt_s = S_WAIT_HDR;
            else       state_nxt_s = state_r;
         end
         S_WAIT_HDR: begin
            if (rx_valid && (rx_data == HDR_BYTE)) state_nxt_s = S_GET_CNT;
            else                                   state_nxt_s = S_WAIT_HDR;
         end
         S_GET_CNT: begin
            if (tmo_s) state_nxt_s = S_ERROR;
            else if (rx_valid) begin
               if ((rx_data == 8'd0) || (rx_data > DEPTH_B)) state_nxt_s = S_ERROR;
               else                                          state_nxt_s = S_GET_HI;
            end
            else state_nxt_s = S_GET_CNT;
         end
         S_GET_HI: begin
            if (tmo_s)         state_nxt_s = S_ERROR;
            else if (rx_valid) state_nxt_s = S_GET_LO;
            else               state_nxt_s = S_GET_HI;
         end
         S_GET_LO: begin
            if (tmo_s)         state_nxt_s = S_ERROR;
            else if (rx_valid) state_nxt_s = (idx_r == n_last_r) ? S_GET_CSUM : S_GET_HI;
            else               state_nxt_s = S_GET_LO;
         end
         S_GET_CSUM: begin
            if (tmo_s)         state_nxt_s = S_ERROR;
            else if (rx_valid) state_nxt_s = (rx_data == csum_r) ? S_DONE : S_ERROR;
            else               state_nxt_s = S_GET_CSUM;
         end
         default: state_nxt_s = S_IDLE;
      endcase
   end

   // State, datapath and registered outputs.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state_r    <= S_IDLE;
         idx_r      <= '0;
         n_last_r   <= '0;
         hi_r       <= 8'd0;
         csum_r     <= 8'd0;
         tcnt_r     <= '0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= 16'd0;
         cpu_nreset <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         busy       <= is_busy(state_nxt_s);
         done       <= (state_nxt_s == S_DONE);
         error      <= (state_nxt_s == S_ERROR);
         // Release only after a full cycle in DONE; a restart drops it on the same edge.
         cpu_nreset <= (state_r == S_DONE) && (state_nxt_s == S_DONE);
         wr_en      <= (state_r == S_GET_LO) && rx_valid;

         if (rx_valid || !in_frame_s) tcnt_r <= '0;
         else                         tcnt_r <= tcnt_r + TW'(1);

         case (state_r)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start) begin
                  idx_r  <= '0;
                  csum_r <= 8'd0;
               end
            end
            S_GET_CNT: begin
               if (rx_valid) begin
                  n_last_r <= ADDR_W'(rx_data - 8'd1);
                  csum_r   <= rx_data;
               end
            end
            S_GET_HI: begin
               if (rx_valid) begin
                  hi_r   <= rx_data;
                  csum_r <= csum_add(csum_r, rx_data);
               end
            end
            S_GET_LO: begin
               if (rx_valid) begin
                  csum_r  <= csum_add(csum_r, rx_data);
                  wr_addr <= idx_r;
                  wr_data <= {hi_r, rx_data};
                  idx_r   <= idx_r + ADDR_W'(1);
               end
            end
            default: begin
               idx_r <= idx_r;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pmem_loader.sv
// Scoreboard bench for pmem_loader: expected writes are queued by the stimulus and
// popped by a monitor on every wr_en; status flags are checked at hand-picked cycles.
module tb_pmem_loader;

   logic        Clock    = 1'b0;
   logic        nReset   = 1'b0;
   logic        start    = 1'b0;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data  = 8'd0;
   logic        wr_en;
   logic [2:0]  wr_addr;
   logic [15:0] wr_data;
   logic        cpu_nreset, busy, done, error;

   int n_cmp = 0;
   int n_bad = 0;
   logic [18:0] exp_q[$];

   pmem_loader #(.DEPTH(8), .ADDR_W(3), .TIMEOUT(1000)) dut (
      .Clock(Clock), .nReset(nReset), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .cpu_nreset(cpu_nreset),
      .busy(busy), .done(done), .error(error)
   );

   always #5 Clock = ~Clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge Clock);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      tick(2);
      rx_data  = b;
      rx_valid = 1'b1;
      tick(1);
      rx_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   // {busy, done, error, cpu_nreset}
   task automatic chk_status(input string name, input logic [3:0] exp);
      chk(name, {28'd0, busy, done, error, cpu_nreset}, {28'd0, exp});
   endtask

   // Monitor: every write strobe must match the next queued expectation.
   always @(negedge Clock) begin
      if (nReset && wr_en) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_write: got addr %0d data 0x%04h expected no write", wr_addr, wr_data);
         end else begin
            chk("write", {13'd0, wr_addr, wr_data}, {13'd0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      logic [7:0] hi, lo, cs;

      // Reset values
      tick(3);
      chk_status("reset_status", 4'b0000);
      chk("reset_wr_en", {31'd0, wr_en}, 32'd0);
      chk("reset_wr_addr", {29'd0, wr_addr}, 32'd0);
      chk("reset_wr_data", {16'd0, wr_data}, 32'd0);
      nReset = 1'b1;
      tick(2);

      // Two-word image; a start mid-frame must be ignored
      exp_q.push_back({3'd0, 16'h1234});
      exp_q.push_back({3'd1, 16'h5678});
      pulse_start();
      chk_status("start_busy", 4'b1000);
      send_byte(8'hA5);
      pulse_start();
      send_byte(8'h02); send_byte(8'h12); send_byte(8'h34);
      send_byte(8'h56); send_byte(8'h78); send_byte(8'h16);
      chk_status("done_entry_cpu_low", 4'b0100);
      tick(1);
      chk_status("done_cpu_released", 4'b0101);

      // Restart from DONE drops cpu_nreset at once; count 0 is an error
      pulse_start();
      chk_status("restart_from_done", 4'b1000);
      send_byte(8'hA5); send_byte(8'h00);
      tick(2);
      chk_status("cnt_zero_error", 4'b0010);
      exp_q.push_back({3'd0, 16'hBEEF});
      pulse_start();
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'hBE); send_byte(8'hEF); send_byte(8'hAE);
      tick(2);
      chk_status("recover_done", 4'b0101);

      // Count above DEPTH, then a full-depth image
      pulse_start();
      send_byte(8'hA5); send_byte(8'h09);
      tick(2);
      chk_status("cnt_over_error", 4'b0010);
      pulse_start();
      send_byte(8'hA5); send_byte(8'h08);
      cs = 8'h08;
      for (int i = 0; i < 8; i++) begin
         hi = 8'(8'h11 * i);
         lo = 8'(8'hF0 + i);
         cs = cs + hi + lo;
         exp_q.push_back({3'(i), hi, lo});
         send_byte(hi); send_byte(lo);
      end
      send_byte(cs);
      tick(2);
      chk_status("full_depth_done", 4'b0101);

      // Bad checksum: one write survives but the CPU stays in reset
      exp_q.push_back({3'd0, 16'hABCD});
      pulse_start();
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'hAB); send_byte(8'hCD); send_byte(8'h00);
      tick(2);
      chk_status("bad_csum_error", 4'b0010);

      // Inter-byte timeout
      pulse_start();
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'hAB);
      tick(990);
      chk_status("before_timeout", 4'b1000);
      tick(15);
      chk_status("after_timeout", 4'b0010);

      // Asynchronous reset in the middle of GET_LO
      pulse_start();
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'hAB);
      tick(1);
      nReset = 1'b0;
      #2;
      chk_status("midframe_reset_status", 4'b0000);
      chk("midframe_reset_wr_data", {16'd0, wr_data}, 32'd0);
      chk("midframe_reset_wr_addr", {29'd0, wr_addr}, 32'd0);
      tick(2);
      nReset = 1'b1;
      tick(2);

      // start with a simultaneous byte: the byte is dropped, then only A5 opens the frame
      exp_q.push_back({3'd0, 16'h1234});
      start    = 1'b1;
      rx_valid = 1'b1;
      rx_data  = 8'hA5;
      tick(1);
      start    = 1'b0;
      rx_valid = 1'b0;
      send_byte(8'h33); send_byte(8'h00); send_byte(8'hA5);
      send_byte(8'h01); send_byte(8'h12); send_byte(8'h34); send_byte(8'h47);
      tick(2);
      chk_status("after_reset_done", 4'b0101);

      tick(5);
      chk("write_queue_drained", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
